// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit for the E stage. It implements MULT, MULTU,
// DIV and DIVU and owns the HI/LO registers. The datapath is radix-2: one
// shift-add (multiply) or one restoring trial-subtract (divide) per cycle,
// working on operand magnitudes. The signs are fixed up in a final cycle.
//
// Parameters:
//   N   operand width; HI and LO are N bits each
//   CW  iteration counter width
//
// Ports:
//   clk     clock, rising edge
//   reset   asynchronous active-low reset
//   start   launch an operation (accepted only in IDLE without flush)
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   flush   abort an in-flight operation; blocks a start in IDLE
//   a, b    multiplicand/dividend, multiplier/divisor
//   hi_we   MTHI write enable (IDLE only)
//   lo_we   MTLO write enable (IDLE only)
//   wdata   MTHI/MTLO data
//   busy    operation in progress (stall request)
//   done    one-cycle pulse after HI/LO were written by an operation
//   hi, lo  HI/LO registers
//
// Optional feature macro: MULDIV_EARLY_EXIT_EN
//   When defined, a multiply with a zero operand and a divide by zero skip
//   the iteration phase and go straight to the final cycle.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int N  = 64,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         flush,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Two's-complement negation of an N-bit value
    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
        return (~v) + {{(N-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a 2N-bit value
    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
        return (~v) + {{(2*N-1){1'b0}}, 1'b1};
    endfunction

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_x;        // product high half / partial remainder
    logic [N-1:0]   r_y;        // multiplier then product low half / dividend then quotient
    logic [N-1:0]   r_m;        // multiplicand magnitude / divisor magnitude
    logic           r_div;
    logic           r_neg_q;    // negate product or quotient
    logic           r_neg_r;    // negate remainder (dividend was negative)
    logic           r_busy;
    logic           r_done;
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;

    logic           w_signed;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic           w_launch;
    logic           w_early;
    logic [N:0]     w_sum;
    logic           w_ge;
    logic [N-1:0]   w_diff;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_res_hi;
    logic [N-1:0]   w_res_lo;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[N-1];
    assign w_b_neg  = w_signed & b[N-1];
    assign w_a_mag  = w_a_neg ? neg_n(a) : a;
    assign w_b_mag  = w_b_neg ? neg_n(b) : b;
    assign w_launch = (r_state == S_IDLE) && start && !flush;

`ifdef MULDIV_EARLY_EXIT_EN
    assign w_early = op[1] ? (b == {N{1'b0}})
                           : ((a == {N{1'b0}}) || (b == {N{1'b0}}));
`else
    assign w_early = 1'b0;
`endif

    // Multiply step: add multiplicand when the current multiplier bit is set
    assign w_sum = {1'b0, r_x} + (r_y[0] ? {1'b0, r_m} : {(N+1){1'b0}});

    // Divide step: shift in next dividend bit, compare against the divisor.
    // Only the low N bits of the difference are kept, so the top bit of the
    // shifted remainder can be dropped from the subtraction itself.
    assign w_ge   = ({r_x, r_y[N-1]} >= {1'b0, r_m});
    assign w_diff = {r_x[N-2:0], r_y[N-1]} - r_m;

    // Sign correction and divide-by-zero override for the final write
    always_comb begin
        w_prod   = r_neg_q ? neg_2n({r_x, r_y}) : {r_x, r_y};
        w_res_hi = {N{1'b0}};
        w_res_lo = {N{1'b0}};
        if (r_div) begin
            // A zero divisor leaves the dividend magnitude in r_x, so the
            // remainder sign fix returns the original dividend.
            w_res_hi = r_neg_r ? neg_n(r_x) : r_x;
            if (r_m == {N{1'b0}}) begin
                w_res_lo = {N{1'b1}};
            end else begin
                w_res_lo = r_neg_q ? neg_n(r_y) : r_y;
            end
        end else begin
            w_res_hi = w_prod[2*N-1:N];
            w_res_lo = w_prod[N-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_next = w_early ? S_FIN : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == {CW{1'b0}}) begin
                    w_state_next = S_FIN;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= {CW{1'b0}};
            r_x     <= {N{1'b0}};
            r_y     <= {N{1'b0}};
            r_m     <= {N{1'b0}};
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= {N{1'b0}};
            r_lo    <= {N{1'b0}};
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // MTHI/MTLO land here; a result written later wins
                    if (hi_we) begin
                        r_hi <= wdata;
                    end
                    if (lo_we) begin
                        r_lo <= wdata;
                    end
                    if (w_launch) begin
                        r_div   <= op[1];
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= CW'(N-1);
                        r_m     <= op[1] ? w_b_mag : w_a_mag;
                        // Early exit preloads what the iterations would produce
                        r_x     <= (w_early && op[1]) ? w_a_mag : {N{1'b0}};
                        r_y     <= op[1] ? w_a_mag : (w_early ? {N{1'b0}} : w_b_mag);
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    if (!r_div) begin
                        r_x <= w_sum[N:1];
                        r_y <= {w_sum[0], r_y[N-1:1]};
                    end else if (w_ge) begin
                        r_x <= w_diff;
                        r_y <= {r_y[N-2:0], 1'b1};
                    end else begin
                        r_x <= {r_x[N-2:0], r_y[N-1]};
                        r_y <= {r_y[N-2:0], 1'b0};
                    end
                end
                S_FIN: begin
                    if (!flush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
